// File: rtl/div_result_fifo.sv
// Result FIFO behind the 10-bit restoring divider: captures {dvz, ovf, q} on div_done
// and hands entries to a valid/ready consumer. Optional counters: `define DIV_RES_STATS_EN.
module div_result_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             div_done,
  input  logic [9:0]       div_q,
  input  logic             div_ovf,
  input  logic             div_dvz,
  input  logic             clr_overrun,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [9:0]       res_q,
  output logic             res_ovf,
  output logic             res_dvz,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             overrun
`ifdef DIV_RES_STATS_EN
  ,
  output logic [7:0]       ovf_cnt,
  output logic [7:0]       dvz_cnt
`endif
);

  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  // A divide-by-zero result carries no meaningful quotient, so it is stored as zero.
  function automatic logic [11:0] pack_entry(input logic [9:0] q, input logic ovf,
                                             input logic dvz);
    logic [9:0] q_eff;
    if (dvz) begin
      q_eff = 10'd0;
    end else begin
      q_eff = q;
    end
    return {dvz, ovf, q_eff};
  endfunction

  logic [11:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;
  logic             drop;
  logic [11:0]      head;

  // Handshake decode; a pop frees a slot on the same edge, so full does not block a push then.
  always_comb begin
    empty     = (count == {(PTR_W+1){1'b0}});
    full      = (count == CNT_FULL);
    res_valid = ~empty;
    rd_en     = res_valid & res_ready;
    wr_en     = div_done & (~full | rd_en);
    drop      = div_done & full & ~rd_en;
  end

  // Head entry straight from storage, forced to zero while empty.
  always_comb begin
    head = 12'd0;
    if (!empty) begin
      head = mem[rd_ptr];
    end else begin
      head = 12'd0;
    end
    res_dvz = head[11];
    res_ovf = head[10];
    res_q   = head[9:0];
  end

  // Storage array; contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !sclr) begin
      mem[wr_ptr] <= pack_entry(div_q, div_ovf, div_dvz);
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {(PTR_W+1){1'b0}};
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun; a drop on the same edge as a clear leaves it set.
  always_ff @(posedge clk) begin
    if (sclr) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

`ifdef DIV_RES_STATS_EN
  // Saturating flag counters over accepted writes only.
  always_ff @(posedge clk) begin
    if (sclr) begin
      ovf_cnt <= 8'd0;
      dvz_cnt <= 8'd0;
    end else begin
      if (wr_en && div_ovf && (ovf_cnt != 8'd255)) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
      if (wr_en && div_dvz && (dvz_cnt != 8'd255)) begin
        dvz_cnt <= dvz_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_div_result_fifo.sv
// Bench for div_result_fifo: a hand-derived vector table plus a queue scoreboard
// that predicts each popped entry and the occupancy/overrun state every cycle.
module tb_div_result_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       sclr = 1'b0;
  logic       div_done = 1'b0;
  logic [9:0] div_q = 10'd0;
  logic       div_ovf = 1'b0;
  logic       div_dvz = 1'b0;
  logic       clr_overrun = 1'b0;
  logic       res_ready = 1'b0;
  logic       res_valid;
  logic [9:0] res_q;
  logic       res_ovf;
  logic       res_dvz;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overrun;
`ifdef DIV_RES_STATS_EN
  logic [7:0] ovf_cnt;
  logic [7:0] dvz_cnt;
`endif

  div_result_fifo #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .sclr(sclr), .div_done(div_done), .div_q(div_q),
    .div_ovf(div_ovf), .div_dvz(div_dvz), .clr_overrun(clr_overrun),
    .res_ready(res_ready), .res_valid(res_valid), .res_q(res_q),
    .res_ovf(res_ovf), .res_dvz(res_dvz), .full(full), .empty(empty),
    .count(count), .overrun(overrun)
`ifdef DIV_RES_STATS_EN
    , .ovf_cnt(ovf_cnt), .dvz_cnt(dvz_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       done;
    logic [9:0] q;
    logic       ovf;
    logic       dvz;
    logic       ready;
    logic       clr;
    logic       rst;
    int         e_count;
    int         e_q;
    int         e_ovf;
    int         e_dvz;
    int         e_ovr;
  } vec_t;

  vec_t        tbl[$];
  logic [11:0] sb[$];
  logic        m_ovr = 1'b0;
  int          errors = 0;
  int          checks = 0;

  function automatic vec_t mk(input logic done, input int q, input logic ovf, input logic dvz,
                              input logic ready, input logic clr, input logic rst,
                              input int e_count, input int e_q, input int e_ovf,
                              input int e_dvz, input int e_ovr);
    vec_t v;
    v.done = done; v.q = q[9:0]; v.ovf = ovf; v.dvz = dvz;
    v.ready = ready; v.clr = clr; v.rst = rst;
    v.e_count = e_count; v.e_q = e_q; v.e_ovf = e_ovf; v.e_dvz = e_dvz; v.e_ovr = e_ovr;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, score the pop/push, then check state after the edge.
  task automatic step(input logic done, input logic [9:0] q, input logic ovf, input logic dvz,
                      input logic ready, input logic clr, input logic rst);
    logic [11:0] exp_e;
    logic        popped;
    logic        set_ovr;
    @(negedge clk);
    div_done = done; div_q = q; div_ovf = ovf; div_dvz = dvz;
    res_ready = ready; clr_overrun = clr; sclr = rst;
    #1;
    popped = 1'b0;
    set_ovr = 1'b0;
    if (rst) begin
      sb.delete();
      m_ovr = 1'b0;
    end else begin
      if (ready && sb.size() > 0) begin
        exp_e = sb.pop_front();
        chk("pop_q", int'(res_q), int'(exp_e[9:0]));
        chk("pop_ovf", int'(res_ovf), int'(exp_e[10]));
        chk("pop_dvz", int'(res_dvz), int'(exp_e[11]));
        popped = 1'b1;
      end
      if (done) begin
        if (sb.size() + (popped ? 1 : 0) < DEPTH || popped) begin
          sb.push_back({dvz, ovf, (dvz ? 10'd0 : q)});
        end else begin
          set_ovr = 1'b1;
          m_ovr = 1'b1;
        end
      end
      if (clr && !set_ovr) m_ovr = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("count", int'(count), sb.size());
    chk("empty", int'(empty), (sb.size() == 0) ? 1 : 0);
    chk("full", int'(full), (sb.size() == DEPTH) ? 1 : 0);
    chk("res_valid", int'(res_valid), (sb.size() != 0) ? 1 : 0);
    chk("overrun", int'(overrun), int'(m_ovr));
    if (sb.size() != 0) begin
      exp_e = sb[0];
    end else begin
      exp_e = 12'd0;
    end
    chk("head_q", int'(res_q), int'(exp_e[9:0]));
    chk("head_flags", int'({res_dvz, res_ovf}), int'(exp_e[11:10]));
  endtask

  initial begin
    // done q ovf dvz rdy clr rst | count head_q head_ovf head_dvz overrun
    tbl.push_back(mk(0,   0, 0, 0, 0, 0, 1,  0,  0, 0, 0, 0));  // reset
    tbl.push_back(mk(1,  37, 0, 0, 0, 0, 0,  1, 37, 0, 0, 0));  // single result
    tbl.push_back(mk(0,   0, 0, 0, 1, 0, 0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(1,   1, 0, 0, 0, 0, 0,  1,  1, 0, 0, 0));  // fill 1..4
    tbl.push_back(mk(1,   2, 0, 0, 0, 0, 0,  2,  1, 0, 0, 0));
    tbl.push_back(mk(1,   3, 0, 0, 0, 0, 0,  3,  1, 0, 0, 0));
    tbl.push_back(mk(1,   4, 0, 0, 0, 0, 0,  4,  1, 0, 0, 0));
    tbl.push_back(mk(0,   0, 0, 0, 0, 0, 0,  4,  1, 0, 0, 0));  // stalled, head stable
    tbl.push_back(mk(1,  99, 0, 0, 0, 0, 0,  4,  1, 0, 0, 1));  // dropped -> overrun
    tbl.push_back(mk(0,   0, 0, 0, 0, 1, 0,  4,  1, 0, 0, 0));  // clear overrun
    tbl.push_back(mk(1,  55, 0, 0, 1, 0, 0,  4,  2, 0, 0, 0));  // full push+pop
    tbl.push_back(mk(0,   0, 0, 0, 1, 0, 0,  3,  3, 0, 0, 0));
    tbl.push_back(mk(0,   0, 0, 0, 1, 0, 0,  2,  4, 0, 0, 0));
    tbl.push_back(mk(0,   0, 0, 0, 1, 0, 0,  1, 55, 0, 0, 0));
    tbl.push_back(mk(0,   0, 0, 0, 1, 0, 0,  0,  0, 0, 0, 0));  // pops 55
    tbl.push_back(mk(1,   7, 0, 0, 1, 0, 0,  1,  7, 0, 0, 0));  // empty push+ready
    tbl.push_back(mk(0,   0, 0, 0, 1, 0, 0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 1023, 0, 1, 0, 0, 0, 1,  0, 0, 1, 0));  // dvz forces q=0
    tbl.push_back(mk(1,   5, 1, 0, 1, 0, 0,  1,  5, 1, 0, 0));
    tbl.push_back(mk(0,   0, 0, 0, 1, 0, 0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(1,  10, 0, 0, 0, 0, 0,  1, 10, 0, 0, 0));
    tbl.push_back(mk(1,  11, 0, 0, 0, 0, 0,  2, 10, 0, 0, 0));
    tbl.push_back(mk(1,  12, 0, 0, 0, 0, 0,  3, 10, 0, 0, 0));
    tbl.push_back(mk(1,  13, 0, 0, 0, 0, 0,  4, 10, 0, 0, 0));
    tbl.push_back(mk(1,  77, 0, 0, 0, 1, 0,  4, 10, 0, 0, 1));  // set beats clear
    tbl.push_back(mk(0,   0, 0, 0, 1, 0, 0,  3, 11, 0, 0, 1));
    tbl.push_back(mk(1,  88, 0, 0, 1, 0, 1,  0,  0, 0, 0, 0));  // reset mid-stream
    tbl.push_back(mk(0,   0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0));  // nothing written
    tbl.push_back(mk(1,  21, 0, 0, 0, 0, 0,  1, 21, 0, 0, 0));
    tbl.push_back(mk(0,   0, 0, 0, 1, 0, 0,  0,  0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].done, tbl[i].q, tbl[i].ovf, tbl[i].dvz, tbl[i].ready, tbl[i].clr, tbl[i].rst);
      chk($sformatf("vec%0d_count", i), int'(count), tbl[i].e_count);
      chk($sformatf("vec%0d_q", i), int'(res_q), tbl[i].e_q);
      chk($sformatf("vec%0d_ovf", i), int'(res_ovf), tbl[i].e_ovf);
      chk($sformatf("vec%0d_dvz", i), int'(res_dvz), tbl[i].e_dvz);
      chk($sformatf("vec%0d_overrun", i), int'(overrun), tbl[i].e_ovr);
    end

`ifdef DIV_RES_STATS_EN
    step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("stats_rst_ovf", int'(ovf_cnt), 0);
    chk("stats_rst_dvz", int'(dvz_cnt), 0);
    step(1'b1, 10'h3FF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stats_dvz_cnt", int'(dvz_cnt), 1);
    chk("stats_ovf_cnt", int'(ovf_cnt), 0);
    step(1'b1, 10'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // dropped, not counted
    chk("stats_ovf_final", int'(ovf_cnt), 2);
    chk("stats_dvz_final", int'(dvz_cnt), 2);
`endif

    // Random traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 10'($urandom_range(0, 1023)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < ((n / 50) % 2 == 0 ? 3 : 7)) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
